linear_layer_start_fifo_srl: RTL



---
 rtl/linear_layer_start_fifo_store.sv | 50 +++++
 rtl/linear_layer_start_fifo_srl.sv | 99 +++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_store.sv
// ----------------------------------------------------------------------------
// linear_layer_start_fifo_store
// Shift-register data store for the start-channel FIFO. On a write, every
// entry moves one slot deeper and the new word lands in slot 0. Reads are
// combinational from the registers at the supplied address. There is no reset,
// so synthesis can map the array onto SRL primitives.
//
// Ports:
//   clk   in   clock
//   we    in   shift-in enable
//   addr  in   read address (ADDR_WIDTH bits)
//   din   in   word shifted into slot 0
//   dout  out  word at slot addr
// ----------------------------------------------------------------------------
module linear_layer_start_fifo_store #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   // When the FIFO is empty, the parent's address wraps to all ones. That
   // address can fall outside a non-power-of-two array, so the read is
   // guarded. The output is a don't-care in that case.
   always_comb begin
      dout = '0;
      if ({1'b0, addr} < DEPTH_W) begin
         dout = mem[addr];
      end
   end

endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// ----------------------------------------------------------------------------
// linear_layer_start_fifo_srl
// Handshake FIFO controller for a start/token channel between a producer and
// a consumer PE. It tracks occupancy and registered full/empty flags, and it
// generates the read address into a shift-register store.
//
// The head of the queue is always at slot count-1. A push shifts the array,
// which moves the head one slot deeper. So a simultaneous push+pop keeps the
// count fixed and exposes the next-oldest word at the same address.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   if_full_n    out  1 = space available (registered)
//   if_write_ce  in   write clock-enable
//   if_write     in   write request
//   if_din       in   write data
//   if_empty_n   out  1 = data available (registered)
//   if_read_ce   in   read clock-enable
//   if_read      in   read request / acknowledge of if_dout
//   if_dout      out  head-of-queue word (show-ahead)
// ----------------------------------------------------------------------------
module linear_layer_start_fifo_srl #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0]   count_reg, count_next;
   logic                  full_n_reg, full_n_next;
   logic                  empty_n_reg, empty_n_next;
   logic                  push, pop;
   logic [ADDR_WIDTH:0]   head_idx;
   logic [ADDR_WIDTH-1:0] addr;

   assign push = if_write & if_write_ce & full_n_reg;
   assign pop  = if_read & if_read_ce & empty_n_reg;

   // When count is 0, the address wraps. if_dout is ignored while empty.
   assign head_idx = count_reg - ONE_W;
   assign addr     = head_idx[ADDR_WIDTH-1:0];

   always_comb begin
      count_next   = count_reg;
      full_n_next  = full_n_reg;
      empty_n_next = empty_n_reg;
      if (push && !pop) begin
         count_next   = count_reg + ONE_W;
         empty_n_next = 1'b1;
         full_n_next  = (count_next != DEPTH_W);
      end else if (pop && !push) begin
         count_next   = count_reg - ONE_W;
         full_n_next  = 1'b1;
         empty_n_next = (count_next != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg   <= '0;
         full_n_reg  <= 1'b1;
         empty_n_reg <= 1'b0;
      end else begin
         count_reg   <= count_next;
         full_n_reg  <= full_n_next;
         empty_n_reg <= empty_n_next;
      end
   end

   assign if_full_n  = full_n_reg;
   assign if_empty_n = empty_n_reg;

   linear_layer_start_fifo_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_store (
      .clk  (clk),
      .we   (push),
      .addr (addr),
      .din  (if_din),
      .dout (if_dout)
   );

endmodule
